// File: rtl/regfile_scan_reader.sv
// Streams every register of the regfile out over valid/ready, forwarding a snooped write
// that lands on the register being captured. Define RSCAN_PARITY_EN to add the out_par_o output.
module regfile_scan_reader #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int GAP   = 0,
  localparam int IW   = $clog2(NREG)
) (
  input  logic                  ck_i,
  input  logic                  res_i,
  input  logic                  start_i,
  input  logic [NREG*WIDTH-1:0] rf_r_i,
  input  logic                  wr_en_i,
  input  logic [IW-1:0]         wr_sel_i,
  input  logic [WIDTH-1:0]      wr_d_i,
  output logic [WIDTH-1:0]      out_data_o,
`ifdef RSCAN_PARITY_EN
  output logic                  out_par_o,
`endif
  output logic [IW-1:0]         out_idx_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAPW, S_DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX   = IW'(NREG - 1);
  localparam logic [7:0]    GAP_RELOAD = 8'((GAP == 0) ? 0 : GAP - 1);

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [IW-1:0]    idx_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             par_q;
  logic [7:0]       gap_cnt_q;

  logic [WIDTH-1:0] reg_w [NREG];
  logic [IW-1:0]    cap_idx_d;
  logic [WIDTH-1:0] cap_data_d;
  logic             cap_last_d;
  logic             capture_en;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_taps
    assign reg_w[gi] = rf_r_i[gi*WIDTH +: WIDTH];
  end

  // Capture target is always reg 0 from IDLE, otherwise the register after the one shown.
  always_comb begin
    cap_idx_d  = (state_q == S_IDLE) ? '0 : idx_q + 1'b1;
    cap_data_d = (wr_en_i && (wr_sel_i == cap_idx_d)) ? wr_d_i : reg_w[cap_idx_d];
    cap_last_d = (cap_idx_d == LAST_IDX);
    capture_en = ((state_q == S_IDLE) && start_i)
              || ((state_q == S_PRESENT) && out_ready_i && !last_q && (GAP == 0))
              || ((state_q == S_GAPW) && (gap_cnt_q == 8'd0));
  end

  always_ff @(posedge ck_i) begin
    if (res_i) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      par_q     <= 1'b0;
      gap_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q  <= 1'b1;
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready_i) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (GAP != 0) begin
              valid_q   <= 1'b0;
              gap_cnt_q <= GAP_RELOAD;
              state_q   <= S_GAPW;
            end
          end
        end
        S_GAPW: begin
          if (gap_cnt_q == 8'd0) begin
            state_q <= S_PRESENT;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Snapshot: the word only changes here, so backpressure holds it regardless of rf_r_i.
      if (capture_en) begin
        data_q  <= cap_data_d;
        idx_q   <= cap_idx_d;
        last_q  <= cap_last_d;
        par_q   <= ^cap_data_d;
        valid_q <= 1'b1;
      end
    end
  end

  assign out_data_o  = data_q;
  assign out_idx_o   = idx_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
`ifdef RSCAN_PARITY_EN
  assign out_par_o   = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Bench for regfile_scan_reader: two instances (GAP=0 and GAP=3) share stimulus and are
// checked every cycle against a behavioural model plus hand-computed stream expectations.
module tb_regfile_scan_reader;
  localparam int WIDTH = 16;
  localparam int NREG  = 4;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  res, start, wr_en, out_ready;
  logic [IW-1:0]         wr_sel;
  logic [WIDTH-1:0]      wr_d;
  logic [NREG*WIDTH-1:0] rf;

  logic [WIDTH-1:0] o_data [2];
  logic [IW-1:0]    o_idx [2];
  logic             o_valid [2], o_last [2], o_busy [2], o_done [2];
`ifdef RSCAN_PARITY_EN
  logic             o_par [2];
`endif

  always #5 clk = ~clk;

  regfile_scan_reader #(.WIDTH(WIDTH), .NREG(NREG), .GAP(0)) u0 (
    .ck_i(clk), .res_i(res), .start_i(start), .rf_r_i(rf),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_d_i(wr_d),
    .out_data_o(o_data[0]),
`ifdef RSCAN_PARITY_EN
    .out_par_o(o_par[0]),
`endif
    .out_idx_o(o_idx[0]), .out_valid_o(o_valid[0]), .out_ready_i(out_ready),
    .out_last_o(o_last[0]), .busy_o(o_busy[0]), .done_o(o_done[0]));

  regfile_scan_reader #(.WIDTH(WIDTH), .NREG(NREG), .GAP(3)) u1 (
    .ck_i(clk), .res_i(res), .start_i(start), .rf_r_i(rf),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_d_i(wr_d),
    .out_data_o(o_data[1]),
`ifdef RSCAN_PARITY_EN
    .out_par_o(o_par[1]),
`endif
    .out_idx_o(o_idx[1]), .out_valid_o(o_valid[1]), .out_ready_i(out_ready),
    .out_last_o(o_last[1]), .busy_o(o_busy[1]), .done_o(o_done[1]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s u%0d: got %h expected %h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_data [2];
  int               m_idx [2];
  int               m_wait [2];
  bit               m_valid [2], m_last [2], m_busy [2], m_done [2], m_par [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [WIDTH-1:0] word_at(input int i);
    if (wr_en && (int'(wr_sel) == i)) return wr_d;
    return rf[i*WIDTH +: WIDTH];
  endfunction

  task automatic show(input int k, input int i);
    m_valid[k] = 1'b1;
    m_idx[k]   = i;
    m_data[k]  = word_at(i);
    m_last[k]  = (i == NREG - 1);
    m_par[k]   = ^word_at(i);
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (res) begin
        armed = 1'b1;
        m_data[k] = '0; m_idx[k] = 0; m_wait[k] = 0; m_par[k] = 1'b0;
        m_valid[k] = 1'b0; m_last[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
      end else if (m_done[k]) begin
        m_done[k] = 1'b0;
      end else if (!m_busy[k]) begin
        if (start) begin
          m_busy[k] = 1'b1;
          show(k, 0);
        end
      end else if (m_valid[k]) begin
        if (out_ready) begin
          if (m_idx[k] == NREG - 1) begin
            m_valid[k] = 1'b0; m_last[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b1;
          end else if (gap_of(k) == 0) begin
            show(k, m_idx[k] + 1);
          end else begin
            m_valid[k] = 1'b0;
            m_wait[k]  = gap_of(k);
          end
        end
      end else begin
        m_wait[k]--;
        if (m_wait[k] == 0) show(k, m_idx[k] + 1);
      end
    end
  end

  // ---------------- compare + stream logging ----------------
  logic [WIDTH-1:0] dlog0[$], dlog1[$];
  int               clog0[$], clog1[$];
  bit               llog0[$], plog0[$];
  int               dn0, dn1, dcyc0;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk("valid", k, 32'(o_valid[k]), 32'(m_valid[k]));
        chk("busy",  k, 32'(o_busy[k]),  32'(m_busy[k]));
        chk("done",  k, 32'(o_done[k]),  32'(m_done[k]));
        chk("last",  k, 32'(o_last[k]),  32'(m_last[k]));
        if (m_valid[k]) begin
          chk("data", k, 32'(o_data[k]), 32'(m_data[k]));
          chk("idx",  k, 32'(o_idx[k]),  32'(m_idx[k]));
`ifdef RSCAN_PARITY_EN
          chk("par",  k, 32'(o_par[k]),  32'(m_par[k]));
`endif
        end
      end
      if (o_valid[0] && out_ready) begin
        dlog0.push_back(o_data[0]); clog0.push_back(cyc); llog0.push_back(o_last[0]);
`ifdef RSCAN_PARITY_EN
        plog0.push_back(o_par[0]);
`endif
      end
      if (o_valid[1] && out_ready) begin
        dlog1.push_back(o_data[1]); clog1.push_back(cyc);
      end
      if (o_done[0]) begin dn0++; dcyc0 = cyc; end
      if (o_done[1]) dn1++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    dlog0.delete(); dlog1.delete(); clog0.delete(); clog1.delete();
    llog0.delete(); plog0.delete();
    dn0 = 0; dn1 = 0; dcyc0 = 0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    step();
    while ((o_busy[0] || o_busy[1] || o_done[0] || o_done[1]) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) begin
      checks++; failures++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", maxc);
    end
  endtask

  task automatic check_cleared(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_valid"}, k, 32'(o_valid[k]), 0);
      chk({nm, "_busy"},  k, 32'(o_busy[k]),  0);
      chk({nm, "_done"},  k, 32'(o_done[k]),  0);
      chk({nm, "_last"},  k, 32'(o_last[k]),  0);
      chk({nm, "_data"},  k, 32'(o_data[k]),  0);
      chk({nm, "_idx"},   k, 32'(o_idx[k]),   0);
    end
  endtask

  task automatic check_seq0(input string nm, input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                            input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
    logic [WIDTH-1:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_len"}, 0, 32'(dlog0.size()), 4);
    for (int i = 0; i < 4 && i < dlog0.size(); i++) begin
      chk({nm, "_word"}, 0, 32'(dlog0[i]), 32'(e[i]));
      chk({nm, "_lastflag"}, 0, 32'(llog0[i]), (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_d = '0; out_ready = 1'b1;
    rf = {16'h0000, 16'hBEEF, 16'h1234, 16'h4C55};
    clear_logs();

    // 1: reset for two cycles (start with reset loses), then idle
    step();
    start = 1'b1;
    step();
    start = 1'b0; res = 1'b0;
    step(); step();
    check_cleared("reset");
    clear_logs();

    // 2: back-to-back scan with ready held high
    start = 1'b1; step(); start = 1'b0;
    wait_idle(60);
    check_seq0("scan", 16'h4C55, 16'h1234, 16'hBEEF, 16'h0000);
    for (int i = 0; i + 1 < clog0.size(); i++) chk("b2b_spacing", 0, 32'(clog0[i+1] - clog0[i]), 1);
    chk("done_count", 0, 32'(dn0), 1);
    if (clog0.size() == 4) chk("done_after_last", 0, 32'(dcyc0), 32'(clog0[3] + 1));
`ifdef RSCAN_PARITY_EN
    if (plog0.size() > 0) chk("par_4c55", 0, 32'(plog0[0]), 1);
`endif
    clear_logs();

    // 3: backpressure on idx1 while rf_r[1] changes underneath
    start = 1'b1; step(); start = 1'b0;
    step();
    out_ready = 1'b0;
    rf[1*WIDTH +: WIDTH] = 16'hFFFF;
    repeat (5) step();
    chk("stall_valid", 0, 32'(o_valid[0]), 1);
    chk("stall_idx", 0, 32'(o_idx[0]), 1);
    chk("stall_data", 0, 32'(o_data[0]), 32'h1234);
    out_ready = 1'b1;
    wait_idle(60);
    check_seq0("stall", 16'h4C55, 16'h1234, 16'hBEEF, 16'h0000);
    rf[1*WIDTH +: WIDTH] = 16'h1234;
    clear_logs();

    // 4: snooped write on the cycle idx2 is captured
    start = 1'b1; step(); start = 1'b0;
    step();
    wr_en = 1'b1; wr_sel = 2'd2; wr_d = 16'hA5A5;
    step();
    wr_en = 1'b0; wr_sel = '0; wr_d = '0;
    wait_idle(60);
    check_seq0("fwd", 16'h4C55, 16'h1234, 16'hA5A5, 16'h0000);
    clear_logs();

    // 5: GAP=3 spacing, extra start mid-scan ignored
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    wait_idle(80);
    repeat (3) step();
    chk("gap_len", 1, 32'(dlog1.size()), 4);
    for (int i = 0; i + 1 < clog1.size(); i++) chk("gap_spacing", 1, 32'(clog1[i+1] - clog1[i]), 4);
    chk("gap_done_count", 1, 32'(dn1), 1);
    chk("gap_u0_len", 0, 32'(dlog0.size()), 4);
    chk("gap_u0_done", 0, 32'(dn0), 1);
    clear_logs();

    // 6: reset during idx2 aborts the scan, no done pulse
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("pre_abort_idx", 0, 32'(o_idx[0]), 2);
    res = 1'b1; step(); res = 1'b0;
    check_cleared("abort");
    repeat (4) step();
    chk("abort_done", 0, 32'(dn0), 0);
    chk("abort_done", 1, 32'(dn1), 0);
    chk("abort_busy", 0, 32'(o_busy[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
